// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch
// and the load/store stage. Only one transaction is in flight at a time. Data
// wins ties unless fetch has already lost STARVE_LIMIT ties in a row. A fetch
// can be cancelled by a redirect; the bus transaction still completes, but its
// result is not returned to fetch.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // mem-stage side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  state_t           state;
  logic             owner_inst;  // 1: fetch owns the transaction in flight
  logic             drop;        // fetch result must be discarded
  logic [CNT_W-1:0] starve_cnt;
  mem_cmd_t         cmd;

  logic tie_to_inst, grant_inst, grant_data, resp_done;

  // Arbitration happens only in IDLE; the reset gate keeps the accept
  // pulses low while resetn is asserted, even if requests are held.
  assign tie_to_inst  = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_inst   = resetn && (state == IDLE) && inst_req && (!data_req || tie_to_inst);
  assign grant_data   = resetn && (state == IDLE) && data_req && !grant_inst;
  assign resp_done    = (state == WAIT) && mem_data_ok;

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = resp_done && owner_inst && !drop;
  assign data_data_ok = resp_done && !owner_inst;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  // Memory command comes straight from the latched request, so it is
  // stable for the whole ISSUE phase regardless of requester inputs.
  assign mem_req      = (state == ISSUE);
  assign mem_wr       = cmd.wr;
  assign mem_wstrb    = cmd.wstrb;
  assign mem_addr     = cmd.addr;
  assign mem_wdata    = cmd.wdata;
  assign arb_busy     = (state != IDLE);

  // Transaction FSM: grant/latch in IDLE, hold the bus request in ISSUE,
  // wait for the response in WAIT; also tracks cancel and starvation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      owner_inst <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= '0;
      cmd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst) begin
            owner_inst <= 1'b1;
            drop       <= inst_cancel;
            cmd        <= '{wr: 1'b0, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0};
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (grant_data) begin
            owner_inst <= 1'b0;
            drop       <= 1'b0;
            cmd        <= '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
            if (inst_req && !tie_to_inst)
              starve_cnt <= starve_cnt + 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (owner_inst && inst_cancel) drop <= 1'b1;
          if (mem_addr_ok) state <= WAIT;
        end
        WAIT: begin
          if (owner_inst && inst_cancel) drop <= 1'b1;
          if (mem_data_ok) begin
            drop  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues requests and pushes
// expected grants, bus commands and responses; monitors compare on every
// DUT output event.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cancel, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_busy;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        is_inst;
    logic [31:0] rdata;
  } resp_t;

  logic [31:0] iq[$];        // pending fetch addresses
  cmd_t        dq[$];        // pending data requests
  logic        exp_grant[$]; // 1 = inst, 0 = data
  cmd_t        exp_mem[$];
  resp_t       exp_resp[$];
  logic [31:0] rq[$];        // read data the memory model returns

  int n_cmp = 0;
  int n_bad = 0;
  int stall_n = 0;
  int resp_dly = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [3:0] ws,
                              input logic [31:0] a, input logic [31:0] wd);
    cmd_t c;
    c.wr = wr; c.wstrb = ws; c.addr = a; c.wdata = wd;
    return c;
  endfunction

  task automatic expect_txn(input logic is_inst, input cmd_t c,
                            input logic [31:0] rd, input logic deliver);
    resp_t r;
    exp_grant.push_back(is_inst);
    exp_mem.push_back(c);
    rq.push_back(rd);
    if (deliver) begin
      r.is_inst = is_inst;
      r.rdata   = rd;
      exp_resp.push_back(r);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(iq.size() == 0 && dq.size() == 0 && exp_grant.size() == 0 &&
                 exp_mem.size() == 0 && exp_resp.size() == 0 && rq.size() == 0 &&
                 !arb_busy) && k < budget);
    chk("drain_timeout", 32'(k >= budget), 0);
  endtask

  // fetch requester: holds inst_req until accepted, then moves to the next
  initial begin : inst_drv
    logic acc;
    inst_req = 1'b0; inst_addr = '0;
    forever begin
      @(negedge clk); acc = inst_addr_ok;
      @(posedge clk); #1;
      if (acc && iq.size() > 0) iq.delete(0);
      if (iq.size() > 0) begin inst_req = 1'b1; inst_addr = iq[0]; end
      else begin inst_req = 1'b0; inst_addr = '0; end
    end
  end

  // mem-stage requester
  initial begin : data_drv
    logic acc;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    forever begin
      @(negedge clk); acc = data_addr_ok;
      @(posedge clk); #1;
      if (acc && dq.size() > 0) dq.delete(0);
      if (dq.size() > 0) begin
        data_req = 1'b1; data_wr = dq[0].wr; data_wstrb = dq[0].wstrb;
        data_addr = dq[0].addr; data_wdata = dq[0].wdata;
      end else begin
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
      end
    end
  end

  // memory: stall_n cycles before accepting, resp_dly cycles before data
  initial begin : mem_model
    int ph, left;
    ph = 0; left = 0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      if (!resetn) begin
        ph = 0; left = 0;
      end else if (ph == 0) begin
        if (mem_req) begin
          if (left < stall_n) left++;
          else begin mem_addr_ok = 1'b1; left = 0; ph = 1; end
        end
      end else begin
        if (left < resp_dly) left++;
        else begin
          mem_data_ok = 1'b1;
          mem_rdata = (rq.size() > 0) ? rq.pop_front() : 32'h0;
          left = 0; ph = 0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic  g;
    cmd_t  m;
    resp_t r;
    forever begin
      @(negedge clk);
      if (inst_addr_ok || data_addr_ok) begin
        if (exp_grant.size() == 0)
          chk("unexpected_grant", 32'({inst_addr_ok, data_addr_ok}), 0);
        else begin
          g = exp_grant.pop_front();
          chk("grant_sel", 32'({inst_addr_ok, data_addr_ok}), g ? 32'd2 : 32'd1);
        end
      end
      if (mem_req) begin
        if (exp_mem.size() == 0)
          chk("unexpected_mem_req", 32'(mem_req), 0);
        else begin
          m = exp_mem[0];
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wr", 32'(mem_wr), 32'(m.wr));
          chk("mem_wstrb", 32'(mem_wstrb), 32'(m.wstrb));
          if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
          if (mem_addr_ok) exp_mem.delete(0);
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_resp.size() == 0)
          chk("unexpected_resp", 32'({inst_data_ok, data_data_ok}), 0);
        else begin
          r = exp_resp.pop_front();
          chk("resp_sel", 32'({inst_data_ok, data_data_ok}), r.is_inst ? 32'd2 : 32'd1);
          chk("resp_rdata", r.is_inst ? inst_rdata : data_rdata, r.rdata);
        end
      end
      if (mem_data_ok) begin
        if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 0);
        if (!data_data_ok) chk("data_rdata_zero", data_rdata, 0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic any_out();
    return |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
             data_rdata, mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, arb_busy};
  endfunction

  initial begin : stim
    int k;
    resetn = 1'b0; inst_cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 32'(any_out()), 0);
    @(negedge clk) resetn = 1'b1;

    // single load, cycle-exact
    dq.push_back(mk(1'b0, 4'h0, 32'h100, 32'h0));
    expect_txn(1'b0, mk(1'b0, 4'h0, 32'h100, 32'h0), 32'hDEADBEEF, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!data_addr_ok && k < 20);
    chk("load_grant_seen", 32'(data_addr_ok), 1);
    @(negedge clk);
    chk("load_c1_mem_req", 32'(mem_req), 1);
    chk("load_c1_busy", 32'(arb_busy), 1);
    @(negedge clk);
    chk("load_c2_data_ok", 32'(data_data_ok), 1);
    chk("load_c2_rdata", data_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("load_c3_busy", 32'(arb_busy), 0);
    wait_idle(50);

    // store held through two stalled ISSUE cycles
    stall_n = 2;
    dq.push_back(mk(1'b1, 4'h3, 32'h200, 32'h12345678));
    expect_txn(1'b0, mk(1'b1, 4'h3, 32'h200, 32'h12345678), 32'h0, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!data_addr_ok && k < 20);
    k = 0;
    do begin @(negedge clk); if (mem_req) k++; end while (!(mem_req && mem_addr_ok) && k < 10);
    chk("store_issue_cycles", 32'(k), 3);
    wait_idle(50);
    stall_n = 0;

    // fixed priority with starvation guard: d d d d i d d d d i d
    for (int i = 0; i < 9; i++) dq.push_back(mk(1'b0, 4'h0, 32'h300 + 32'(4*i), 32'h0));
    for (int j = 0; j < 2; j++) iq.push_back(32'h1000 + 32'(4*j));
    for (int i = 0; i < 4; i++)
      expect_txn(1'b0, mk(1'b0, 4'h0, 32'h300 + 32'(4*i), 32'h0), 32'hD000_0000 + 32'(i), 1'b1);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h1000, 32'h0), 32'h1000_0000, 1'b1);
    for (int i = 4; i < 8; i++)
      expect_txn(1'b0, mk(1'b0, 4'h0, 32'h300 + 32'(4*i), 32'h0), 32'hD000_0000 + 32'(i), 1'b1);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h1004, 32'h0), 32'h1000_0001, 1'b1);
    expect_txn(1'b0, mk(1'b0, 4'h0, 32'h320, 32'h0), 32'hD000_0008, 1'b1);
    wait_idle(300);

    // cancel in WAIT: fetch result dropped
    resp_dly = 1;
    iq.push_back(32'h2000);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h2000, 32'h0), 32'hCAFE0001, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(mem_req && mem_addr_ok) && k < 20);
    @(posedge clk); #1 inst_cancel = 1'b1;
    @(posedge clk); #1 inst_cancel = 1'b0;
    wait_idle(50);

    // cancel while data owns the port: no effect
    dq.push_back(mk(1'b0, 4'h0, 32'h400, 32'h0));
    expect_txn(1'b0, mk(1'b0, 4'h0, 32'h400, 32'h0), 32'h0BAD_CAFE, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(mem_req && mem_addr_ok) && k < 20);
    @(posedge clk); #1 inst_cancel = 1'b1;
    @(posedge clk); #1 inst_cancel = 1'b0;
    wait_idle(50);
    resp_dly = 0;

    // cancel in the granting cycle
    inst_cancel = 1'b1;
    iq.push_back(32'h2100);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h2100, 32'h0), 32'hCAFE0002, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!inst_addr_ok && k < 20);
    @(posedge clk); #1 inst_cancel = 1'b0;
    wait_idle(50);

    // normal fetch after cancels
    iq.push_back(32'hBFC00000);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'hBFC00000, 32'h0), 32'h3C1DBFC0, 1'b1);
    wait_idle(50);

    // reset in WAIT abandons the transaction
    resp_dly = 3;
    iq.push_back(32'h3000);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h3000, 32'h0), 32'h5555AAAA, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(mem_req && mem_addr_ok) && k < 20);
    @(posedge clk); #1 resetn = 1'b0;
    #1 chk("midreset_outputs", 32'(any_out()), 0);
    iq.delete(); dq.delete(); exp_grant.delete(); exp_mem.delete(); exp_resp.delete(); rq.delete();
    resp_dly = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // fresh fetch completes in 3 cycles
    iq.push_back(32'h4000);
    expect_txn(1'b1, mk(1'b0, 4'h0, 32'h4000, 32'h0), 32'h600DF00D, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!inst_addr_ok && k < 20);
    chk("post_reset_grant_seen", 32'(inst_addr_ok), 1);
    @(negedge clk);
    @(negedge clk);
    chk("post_reset_c2_data_ok", 32'(inst_data_ok), 1);
    chk("post_reset_c2_rdata", inst_rdata, 32'h600DF00D);
    wait_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
